mem_port_arbiter: RTL

Shares the single unified memory port between the fetch stage (instruction reads) and the memory stage (loads/stores raised by the control unit's `loadReq`/`storeReq`). It sequences one memory transaction at a time and buffers completed results while the other requester is still waiting. It also generates the `memStall` signal that the control unit uses to freeze `pc_en` and `pipe_en`. Data accesses have priority, and a fairness counter bounds instruction-fetch starvation.

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction
// at a time, buffering finished results until both requesters are satisfied.
module mem_port_arbiter #(
  parameter int FAIR_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        flush,
  input  logic        d_load,
  input  logic        d_store,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        memStall
);
  localparam logic [3:0] FAIR_MAX = 4'(FAIR_LIMIT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_cmd_t;

  state_t      state, state_nxt;
  mem_cmd_t    cmd_q, cmd_nxt;
  logic        owner_d, owner_d_nxt;
  logic [3:0]  fair_cnt, fair_nxt;
  logic        d_done, i_done, killed;
  logic [31:0] d_buf, i_buf;
  logic        d_pend, i_pend, pick_d, pick_i, rsp, d_cpl, i_cpl, i_busy;

  assign d_pend = (d_load | d_store) & ~d_done;
  assign i_pend = if_req & ~i_done & ~flush;
  // Data normally wins; a saturated fairness count hands the port to a waiting fetch.
  assign pick_d = (state == IDLE) & d_pend & ~((fair_cnt == FAIR_MAX) & i_pend);
  assign pick_i = (state == IDLE) & i_pend & ~pick_d;
  assign rsp    = (state == WAIT) & mem_rvalid;
  assign d_cpl  = rsp & owner_d;
  assign i_cpl  = rsp & ~owner_d & ~killed & ~flush;
  assign i_busy = (state != IDLE) & ~owner_d & ~rsp;

  assign d_valid  = d_done | d_cpl;
  assign d_rdata  = d_done ? d_buf : (d_cpl ? mem_rdata : '0);
  assign if_valid = i_done | i_cpl;
  assign if_rdata = i_done ? i_buf : (i_cpl ? mem_rdata : '0);
  assign memStall = (if_req & ~if_valid) | ((d_load | d_store) & ~d_valid);

  assign mem_req   = (state == REQ);
  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign mem_be    = cmd_q.be;

  always_comb begin
    state_nxt   = state;
    cmd_nxt     = cmd_q;
    owner_d_nxt = owner_d;
    fair_nxt    = fair_cnt;
    case (state)
      IDLE: begin
        if (pick_d) begin
          // A simultaneous load and store is issued as the store.
          cmd_nxt     = '{we: d_store, addr: d_addr,
                          wdata: d_store ? d_wdata : 32'h0,
                          be: d_store ? d_be : 4'hF};
          owner_d_nxt = 1'b1;
          state_nxt   = REQ;
          if (if_req && fair_cnt != FAIR_MAX) fair_nxt = fair_cnt + 4'd1;
        end else if (pick_i) begin
          cmd_nxt     = '{we: 1'b0, addr: if_addr, wdata: 32'h0, be: 4'hF};
          owner_d_nxt = 1'b0;
          state_nxt   = REQ;
          fair_nxt    = '0;
        end
      end
      REQ:     if (mem_gnt) state_nxt = WAIT;
      WAIT:    if (mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!if_req) fair_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cmd_q    <= '0;
      owner_d  <= 1'b0;
      fair_cnt <= '0;
      d_done   <= 1'b0;
      i_done   <= 1'b0;
      killed   <= 1'b0;
      d_buf    <= '0;
      i_buf    <= '0;
    end else begin
      state    <= state_nxt;
      cmd_q    <= cmd_nxt;
      owner_d  <= owner_d_nxt;
      fair_cnt <= fair_nxt;
      // Results are held only while the other side still stalls the pipeline.
      if (!memStall) begin
        d_done <= 1'b0;
        i_done <= 1'b0;
      end else begin
        if (d_cpl) begin
          d_done <= 1'b1;
          d_buf  <= mem_rdata;
        end
        if (i_cpl) begin
          i_done <= 1'b1;
          i_buf  <= mem_rdata;
        end
      end
      if (flush) i_done <= 1'b0;
      if (rsp || pick_i) killed <= 1'b0;
      // A redirected fetch still drains on the port but its data is dropped.
      if (flush && i_busy) killed <= 1'b1;
    end
  end
endmodule
